// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared types and constants for the shift-add multiplier.
// State encodings and the fixed operand width.
package seq_shift_add_multiplier_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_shift_add_multiplier_eightbitadder.sv
// 8-bit ripple-carry adder used as the multiplier add stage.
// Purely combinational.
module eightbitadder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) |
                    (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[8];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned 8x8 sequential shift-add multiplier.
// One partial-product add per cycle, valid/ready on both sides.
module seq_shift_add_multiplier
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  state_t state, state_nxt;

  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] h_q;
  logic [WIDTH-1:0] q_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               last;
  logic [2*WIDTH-1:0] step;

  assign add_b = q_q[0] ? m_q : '0;

  eightbitadder u_add (
    .a    (h_q),
    .b    (add_b),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout)
  );

  // carry lands in the top bit of H, Q shifts right
  assign step = {cout, sum, q_q[WIDTH-1:1]};
  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q   <= '0;
      h_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      p     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            m_q   <= a;
            q_q   <= b;
            h_q   <= '0;
            cnt_q <= '0;
          end
        end
        S_RUN: begin
          {h_q, q_q} <= step;
          cnt_q      <= cnt_q + 1'b1;
          if (last) p <= step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier.
// Directed vector table plus multi-cycle corner sequences.
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  seq_shift_add_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand pair from IDLE, wait for the product, check it.
  task automatic do_op(input logic [7:0] va,
                       input logic [7:0] vb,
                       input logic [15:0] vp,
                       input string name);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    chk({name, " ready"}, 16'(in_ready), 16'd1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'h5A;
    b = 8'hC3;
    chk({name, " busy"}, {15'd0, busy, in_ready}, 16'd2);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    chk({name, " latency"}, 16'(n), 16'd8);
    chk({name, " p"}, p, vp);
    tick();
    chk({name, " idle"}, {14'd0, in_ready, out_valid}, 16'd2);
  endtask

  logic [15:0] exp_q[3];
  int t_out[3];
  int n_out;

  initial begin
    vecs[0] = '{8'h0D, 8'h0B, 16'h008F};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hFF, 16'h0000};
    vecs[3] = '{8'hA5, 8'h00, 16'h0000};
    vecs[4] = '{8'h12, 8'h34, 16'h03A8};
    vecs[5] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[6] = '{8'h80, 8'h02, 16'h0100};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset flags", {13'd0, in_ready, out_valid, busy}, 16'd4);
    chk("reset p", p, 16'h0000);
    rst = 1'b0;
    tick();

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // Back-pressure: product held, new operands ignored.
    out_ready = 1'b0;
    a = 8'h80;
    b = 8'h02;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    chk("bp valid", 16'(out_valid), 16'd1);
    for (int k = 0; k < 5; k++) begin
      a = 8'h11;
      b = 8'h22;
      in_valid = k[0];
      tick();
      chk("bp hold p", p, 16'h0100);
      chk("bp hold flags", {14'd0, in_ready, out_valid}, 16'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp release", {14'd0, in_ready, out_valid}, 16'd2);
    do_op(8'h11, 8'h22, 16'h0242, "after bp");

    // Reset in the middle of RUN.
    a = 8'h12;
    b = 8'h34;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("pre-rst busy", 16'(busy), 16'd1);
    rst = 1'b1;
    #1;
    chk("rst flags", {13'd0, in_ready, out_valid, busy}, 16'd4);
    chk("rst p", p, 16'h0000);
    #2;
    rst = 1'b0;
    tick();
    do_op(8'h12, 8'h34, 16'h03A8, "post-rst");

    // Back-to-back with in_valid held high.
    exp_q[0] = 16'h000F;
    exp_q[1] = 16'h0100;
    exp_q[2] = 16'h00FF;
    n_out = 0;
    fork
      begin
        logic [7:0] pa[3];
        logic [7:0] pb[3];
        logic hs;
        int n;
        pa[0] = 8'h03; pb[0] = 8'h05;
        pa[1] = 8'h10; pb[1] = 8'h10;
        pa[2] = 8'hFF; pb[2] = 8'h01;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
          a = pa[k];
          b = pb[k];
          n = 0;
          do begin
            hs = in_ready;
            tick();
            n++;
          end while (!hs && n < 30);
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          tick();
          if (out_valid) begin
            if (n_out < 3) begin
              chk($sformatf("b2b p%0d", n_out), p, exp_q[n_out]);
              t_out[n_out] = cyc;
            end
            n_out++;
          end
        end
      end
    join
    chk("b2b count", 16'(n_out), 16'd3);
    if (n_out >= 3) begin
      chk("b2b gap1", 16'(t_out[1] - t_out[0]), 16'd10);
      chk("b2b gap2", 16'(t_out[2] - t_out[1]), 16'd10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
